// File: rtl/sum_fp_arbiter.sv
// Two-port valid/ready front-end for the S16.14 + S12.11 adder; result 2 edges after grant, held until consumed.
// Define SUM_FP_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module sum_fp_arbiter #(
   parameter int NB_IN_A  = 16,
   parameter int NBF_IN_A = 14,
   parameter int NB_IN_B  = 12,
   parameter int NBF_IN_B = 11,
   parameter int NB_OUT   = 17
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic                i_req0_valid,
   output logic                o_req0_ready,
   input  logic [NB_IN_A-1:0]  i_req0_a,
   input  logic [NB_IN_B-1:0]  i_req0_b,
   input  logic [1:0]          i_req0_mode,
   input  logic                i_req1_valid,
   output logic                o_req1_ready,
   input  logic [NB_IN_A-1:0]  i_req1_a,
   input  logic [NB_IN_B-1:0]  i_req1_b,
   input  logic [1:0]          i_req1_mode,
   output logic                o_res_valid,
   input  logic                i_res_ready,
   output logic [NB_OUT-1:0]   o_res_data,
   output logic                o_res_id,
   output logic [1:0]          o_res_mode,
   output logic                o_busy
);

   localparam int SH    = NBF_IN_A - NBF_IN_B;
   localparam int NB_T  = 11;
   localparam int LSB_T = 4;
   localparam int NB_R  = 9;
   localparam int LSB_R = 6;

   localparam logic [NB_OUT-1:0] T_MAX    = NB_OUT'((1 << (NB_T - 1)) - 1);
   localparam logic [NB_OUT-1:0] T_MIN    = ~T_MAX;
   localparam logic [NB_OUT-1:0] R_MAX    = NB_OUT'((1 << (NB_R - 1)) - 1);
   localparam logic [NB_OUT-1:0] R_MIN    = ~R_MAX;
   localparam logic [NB_OUT:0]   RND_HALF = (NB_OUT + 1)'(1 << (LSB_R - 1));

   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

   state_t               r_state;
   logic [NB_IN_A-1:0]   r_a;
   logic [NB_IN_B-1:0]   r_b;
   logic [1:0]           r_mode;
   logic                 r_id;
`ifndef SUM_FP_ARB_FIXED_PRIO_EN
   logic                 r_ptr;
`endif

   logic                 w_gnt0;
   logic                 w_gnt1;
   logic [NB_OUT-1:0]    w_a_ext;
   logic [NB_OUT-1:0]    w_b_ext;
   logic [NB_OUT-1:0]    w_full;
   logic [NB_OUT:0]      w_rnd;
   logic [NB_OUT-NB_T-LSB_T:0] w_hi_t;
   logic [NB_OUT-NB_R-LSB_R+1:0] w_hi_r;
   logic                 w_ovf_t;
   logic                 w_ovf_r;
   logic [NB_OUT-1:0]    w_res;
   logic                 w_unused;

   // Grants only in IDLE and never while reset is asserted.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!i_rst && r_state == IDLE) begin
`ifdef SUM_FP_ARB_FIXED_PRIO_EN
         w_gnt0 = i_req0_valid;
         w_gnt1 = i_req1_valid && !i_req0_valid;
`else
         if (i_req0_valid && i_req1_valid) begin
            w_gnt0 = !r_ptr;
            w_gnt1 = r_ptr;
         end else begin
            w_gnt0 = i_req0_valid;
            w_gnt1 = i_req1_valid;
         end
`endif
      end
   end

   assign o_req0_ready = w_gnt0;
   assign o_req1_ready = w_gnt1;

   // Align B's binary point to A's before the add.
   assign w_a_ext = {{(NB_OUT - NB_IN_A){r_a[NB_IN_A-1]}}, r_a};
   assign w_b_ext = {{(NB_OUT - NB_IN_B - SH){r_b[NB_IN_B-1]}}, r_b, {SH{1'b0}}};
   assign w_full  = w_a_ext + w_b_ext;
   assign w_rnd   = {w_full[NB_OUT-1], w_full} + RND_HALF;

   assign w_hi_t   = w_full[NB_OUT-1:LSB_T+NB_T-1];
   assign w_hi_r   = w_rnd[NB_OUT:LSB_R+NB_R-1];
   assign w_ovf_t  = !((&w_hi_t) || (~|w_hi_t));
   assign w_ovf_r  = !((&w_hi_r) || (~|w_hi_r));
   assign w_unused = ^w_rnd[LSB_R-1:0];

   always_comb begin
      w_res = w_full;
      case (r_mode)
         2'd1: w_res = {{(NB_OUT - NB_T){w_full[LSB_T+NB_T-1]}}, w_full[LSB_T+NB_T-1:LSB_T]};
         2'd2: begin
            if (w_ovf_t) w_res = w_full[NB_OUT-1] ? T_MIN : T_MAX;
            else         w_res = {{(NB_OUT - NB_T){w_full[LSB_T+NB_T-1]}}, w_full[LSB_T+NB_T-1:LSB_T]};
         end
         2'd3: begin
            if (w_ovf_r) w_res = w_rnd[NB_OUT] ? R_MIN : R_MAX;
            else         w_res = {{(NB_OUT - NB_R){w_rnd[LSB_R+NB_R-1]}}, w_rnd[LSB_R+NB_R-1:LSB_R]};
         end
         default: w_res = w_full;
      endcase
   end

   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_mode      <= '0;
         r_id        <= 1'b0;
`ifndef SUM_FP_ARB_FIXED_PRIO_EN
         r_ptr       <= 1'b0;
`endif
         o_res_valid <= 1'b0;
         o_res_data  <= '0;
         o_res_id    <= 1'b0;
         o_res_mode  <= '0;
         o_busy      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt0 || w_gnt1) begin
                  r_a     <= w_gnt1 ? i_req1_a    : i_req0_a;
                  r_b     <= w_gnt1 ? i_req1_b    : i_req0_b;
                  r_mode  <= w_gnt1 ? i_req1_mode : i_req0_mode;
                  r_id    <= w_gnt1;
`ifndef SUM_FP_ARB_FIXED_PRIO_EN
                  r_ptr   <= !w_gnt1;
`endif
                  o_busy  <= 1'b1;
                  r_state <= CALC;
               end
            end
            CALC: begin
               o_res_data  <= w_res;
               o_res_id    <= r_id;
               o_res_mode  <= r_mode;
               o_res_valid <= 1'b1;
               r_state     <= HOLD;
            end
            HOLD: begin
               if (i_res_ready) begin
                  o_res_valid <= 1'b0;
                  o_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sum_fp_arbiter.sv
// Directed test-plan vectors plus a randomized run scored against an arithmetic reference model.
module tb_sum_fp_arbiter;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_req0_valid, i_req1_valid;
   logic        o_req0_ready, o_req1_ready;
   logic [15:0] i_req0_a, i_req1_a;
   logic [11:0] i_req0_b, i_req1_b;
   logic [1:0]  i_req0_mode, i_req1_mode;
   logic        o_res_valid, i_res_ready;
   logic [16:0] o_res_data;
   logic        o_res_id;
   logic [1:0]  o_res_mode;
   logic        o_busy;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sum_fp_arbiter dut (
      .clk(clk), .i_rst(i_rst),
      .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
      .i_req0_a(i_req0_a), .i_req0_b(i_req0_b), .i_req0_mode(i_req0_mode),
      .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
      .i_req1_a(i_req1_a), .i_req1_b(i_req1_b), .i_req1_mode(i_req1_mode),
      .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
      .o_res_data(o_res_data), .o_res_id(o_res_id), .o_res_mode(o_res_mode),
      .o_busy(o_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: real-valued sum in units of 2^-14, then requantize.
   function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [11:0] b,
                                           input logic [1:0] mode);
      int full;
      int v;
      full = $signed(a) + $signed(b) * 8;
      case (mode)
         2'd0: v = full;
         2'd1: begin
            v = full >>> 4;
            v = ((v % 2048) + 2048) % 2048;
            if (v >= 1024) v = v - 2048;
         end
         2'd2: v = (full > 16383) ? 1023 : (full < -16384) ? -1024 : (full >>> 4);
         default: begin
            full = full + 32;
            v = (full > 16383) ? 255 : (full < -16384) ? -256 : (full >>> 6);
         end
      endcase
      return 17'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   task automatic txn(input bit id, input logic [15:0] a, input logic [11:0] b,
                      input logic [1:0] m, input logic [16:0] exp, input string tag);
      i_res_ready = 1'b1;
      if (id) begin
         i_req1_valid = 1'b1; i_req1_a = a; i_req1_b = b; i_req1_mode = m;
      end else begin
         i_req0_valid = 1'b1; i_req0_a = a; i_req0_b = b; i_req0_mode = m;
      end
      @(negedge clk);
      chk({tag, "_rdy"}, 32'({o_req1_ready, o_req0_ready}), id ? 32'h2 : 32'h1);
      tick();
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      chk({tag, "_calc"}, 32'({o_res_valid, o_busy}), 32'h1);
      tick();
      chk({tag, "_vld"}, 32'(o_res_valid), 32'h1);
      chk({tag, "_data"}, 32'(o_res_data), 32'(exp));
      chk({tag, "_id"}, 32'({o_res_id, o_res_mode}), 32'({id, m}));
      tick();
      chk({tag, "_done"}, 32'({o_res_valid, o_busy}), 32'h0);
   endtask

   logic [19:0] exp_q[$];
   logic [19:0] e;
   int          g_id[$];
   int          g_cyc[$];
   logic [16:0] held;
   bit          m_busy, m_ptr, g0, g1;

   initial begin
      i_rst = 1'b1;
      i_req0_valid = 1'b1; i_req0_a = 16'h4000; i_req0_b = 12'h400; i_req0_mode = 2'd0;
      i_req1_valid = 1'b0; i_req1_a = '0; i_req1_b = '0; i_req1_mode = '0;
      i_res_ready = 1'b1;

      // Reset with a pending request: nothing may be granted or accepted.
      tick();
      tick();
      @(negedge clk);
      chk("rst_rdy", 32'({o_req1_ready, o_req0_ready}), 32'h0);
      chk("rst_out", 32'({o_res_valid, o_res_id, o_res_mode, o_busy}), 32'h0);
      chk("rst_data", 32'(o_res_data), 32'h0);
      tick();
      i_req0_valid = 1'b0;
      i_rst = 1'b0;
      chk("rst_noacc", 32'(o_busy), 32'h0);

      txn(1'b0, 16'h4000, 12'h400, 2'd0, 17'h06000, "full_pos");
      txn(1'b1, 16'h6000, 12'h400, 2'd1, 17'h00000, "wrap");
      txn(1'b1, 16'h6000, 12'h400, 2'd2, 17'h003FF, "sat_pos");
      txn(1'b1, 16'h6000, 12'h400, 2'd3, 17'h000FF, "rsat_pos");
      txn(1'b0, 16'h8000, 12'h800, 2'd0, 17'h14000, "full_neg");
      txn(1'b0, 16'h8000, 12'h800, 2'd2, 17'h1FC00, "sat_neg");
      txn(1'b1, 16'h8000, 12'h800, 2'd3, 17'h1FF00, "rsat_neg");
      txn(1'b0, 16'h0020, 12'h000, 2'd3, 17'h00001, "rnd_up");
      txn(1'b1, 16'h001F, 12'h000, 2'd3, 17'h00000, "rnd_down");

      // Both requesters valid continuously from reset.
      do_reset();
      i_req0_valid = 1'b1; i_req1_valid = 1'b1; i_res_ready = 1'b1;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         chk("rr_onehot", 32'(o_req0_ready & o_req1_ready), 32'h0);
         if (o_req0_ready || o_req1_ready) begin
            g_id.push_back(o_req1_ready ? 1 : 0);
            g_cyc.push_back(c);
         end
         tick();
      end
      chk("rr_count", 32'(g_id.size()), 32'd5);
      for (int k = 0; k < g_id.size(); k++) begin
`ifdef SUM_FP_ARB_FIXED_PRIO_EN
         chk("rr_order", 32'(g_id[k]), 32'd0);
`else
         chk("rr_order", 32'(g_id[k]), 32'(k % 2));
`endif
         chk("rr_cycle", 32'(g_cyc[k]), 32'(3 * k));
      end

      // Stall in HOLD, then reset out of it.
      do_reset();
      i_res_ready = 1'b0;
      i_req0_valid = 1'b1; i_req0_a = 16'h4000; i_req0_b = 12'h400; i_req0_mode = 2'd0;
      tick();
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b1;
      tick();
      held = ref_sum(16'h4000, 12'h400, 2'd0);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_vld", 32'({o_res_valid, o_busy}), 32'h3);
         chk("hold_data", 32'(o_res_data), 32'(held));
         chk("hold_rdy", 32'({o_req1_ready, o_req0_ready}), 32'h0);
         tick();
      end
      i_rst = 1'b1;
      tick();
      chk("hold_rst", 32'({o_res_valid, o_busy}), 32'h0);
      chk("hold_rst_data", 32'(o_res_data), 32'h0);
      i_rst = 1'b0;
      i_req1_valid = 1'b0;

      // Randomized traffic against the reference model.
      do_reset();
      m_busy = 1'b0;
      m_ptr  = 1'b0;
      for (int c = 0; c < 400; c++) begin
         i_req0_valid = 1'($urandom_range(0, 1));
         i_req1_valid = 1'($urandom_range(0, 1));
         i_req0_a = 16'($urandom); i_req0_b = 12'($urandom); i_req0_mode = 2'($urandom);
         i_req1_a = 16'($urandom); i_req1_b = 12'($urandom); i_req1_mode = 2'($urandom);
         i_res_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         g0 = 1'b0;
         g1 = 1'b0;
         if (!m_busy) begin
            if (i_req0_valid && i_req1_valid) begin
`ifdef SUM_FP_ARB_FIXED_PRIO_EN
               g0 = 1'b1;
`else
               g0 = !m_ptr;
               g1 = m_ptr;
`endif
            end else begin
               g0 = i_req0_valid;
               g1 = i_req1_valid;
            end
         end
         chk("rnd_rdy", 32'({o_req1_ready, o_req0_ready}), 32'({g1, g0}));
         chk("rnd_busy", 32'(o_busy), 32'(m_busy));
         if (o_res_valid && i_res_ready) begin
            if (exp_q.size() == 0) begin
               chk("rnd_spurious", 32'(o_res_valid), 32'h0);
            end else begin
               e = exp_q.pop_front();
               chk("rnd_res", 32'({o_res_id, o_res_mode, o_res_data}), 32'(e));
               m_busy = 1'b0;
            end
         end
         if (g0 || g1) begin
            if (g1) exp_q.push_back({1'b1, i_req1_mode, ref_sum(i_req1_a, i_req1_b, i_req1_mode)});
            else    exp_q.push_back({1'b0, i_req0_mode, ref_sum(i_req0_a, i_req0_b, i_req0_mode)});
            m_busy = 1'b1;
            m_ptr  = g0;
         end
         tick();
      end
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      i_res_ready  = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (o_res_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("drain_res", 32'({o_res_id, o_res_mode, o_res_data}), 32'(e));
         end
         tick();
      end
      chk("drain_empty", 32'(exp_q.size()), 32'h0);
      chk("drain_idle", 32'({o_res_valid, o_busy}), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
